if_fetch_stage: RTL

- Instruction-fetch stage; the producer end of the IF/ID interface whose consumer is the decode stage.
- Holds the PC and fetches from instruction memory over a req/ack handshake with variable latency.
- Drives the IF/ID pipeline register: pc4, inst, inst_valid.
- Consumes the redirect information (pcsource, bpc, jpc) returned from decode, and the hazard-unit stall.

---
 rtl/if_fetch_stage_pkg.sv | 23 ++
 rtl/if_fetch_stage_npc_sel.sv | 23 ++
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC selects,
// fetch FSM states and the default reset PC.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_RSV = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10,
    HOLD = 2'b11
  } fetch_state_e;

  function automatic logic is_redirect_sel(input logic [1:0] pcsource);
    return (pcsource == PCS_BR) || (pcsource == PCS_JMP);
  endfunction

endpackage

// File: rtl/if_fetch_stage_npc_sel.sv
// Next-PC mux: sequential, branch, reserved (sequential) or jump target.
module npc_sel
  import if_fetch_stage_pkg::*;
(
  input  logic [31:0] seq_pc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  always_comb begin
    npc = seq_pc;
    case (pcsource)
      PCS_SEQ: npc = seq_pc;
      PCS_BR:  npc = bpc;
      PCS_RSV: npc = seq_pc;
      PCS_JMP: npc = jpc;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory
// handshake and drives the IF/ID register (pc4, inst, inst_valid).
//
// state | meaning
// IDLE  | one quiet cycle after reset, no request
// REQ   | request outstanding at pc
// DROP  | redirect arrived mid-fetch; finish old fetch, discard, then go to saved target
// HOLD  | fetched word parked in hold buffer while stall is high
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  pc4_nxt, inst_nxt;
  logic         valid_nxt;
  logic [31:0]  hold_inst, hold_inst_nxt;
  logic [31:0]  hold_pc4, hold_pc4_nxt;
  logic [31:0]  redir_pc, redir_pc_nxt;
  logic [31:0]  pc_plus4;
  logic [31:0]  npc;
  logic         redirect;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // Decode only acts on a live instruction that is actually leaving IF/ID.
  assign redirect  = inst_valid & ~stall & is_redirect_sel(pcsource);

  npc_sel u_npc_sel (
    .seq_pc   (pc_plus4),
    .bpc      (bpc),
    .jpc      (jpc),
    .pcsource (pcsource),
    .npc      (npc)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pc4        <= 32'd0;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      hold_inst  <= 32'd0;
      hold_pc4   <= 32'd0;
      redir_pc   <= 32'd0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pc4        <= pc4_nxt;
      inst       <= inst_nxt;
      inst_valid <= valid_nxt;
      hold_inst  <= hold_inst_nxt;
      hold_pc4   <= hold_pc4_nxt;
      redir_pc   <= redir_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pc4_nxt       = pc4;
    inst_nxt      = inst;
    valid_nxt     = inst_valid;
    hold_inst_nxt = hold_inst;
    hold_pc4_nxt  = hold_pc4;
    redir_pc_nxt  = redir_pc;
    imem_req      = 1'b0;

    case (state)
      IDLE: state_nxt = REQ;

      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt    = npc;
            valid_nxt = 1'b0;
          end else if (!stall) begin
            inst_nxt  = imem_rdata;
            pc4_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
          end else begin
            hold_inst_nxt = imem_rdata;
            hold_pc4_nxt  = pc_plus4;
            pc_nxt        = pc_plus4;
            state_nxt     = HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so park the target.
          redir_pc_nxt = npc;
          valid_nxt    = 1'b0;
          state_nxt    = DROP;
        end else if (!stall) begin
          valid_nxt = 1'b0;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_nxt    = redir_pc;
          state_nxt = REQ;
        end
      end

      HOLD: begin
        if (!stall) begin
          state_nxt = REQ;
          if (redirect) begin
            pc_nxt    = npc;
            valid_nxt = 1'b0;
          end else begin
            inst_nxt  = hold_inst;
            pc4_nxt   = hold_pc4;
            valid_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
